// File: rtl/univ_shift_reg_seq_if.sv
// Command/status bundle for univ_shift_reg_seq.
// master: issues commands (op/amount/load_data + serial fill bits), observes status.
// slave : the shift register itself.
//   cmd_valid/cmd_ready : command handshake (accept = valid & ready at a rising edge)
//   op, amount, load_data : command fields, sampled only at the accept edge
//   serial_l / serial_r : fill bits for SHL / SHR, sampled live at every step edge
//   Q, busy, done, ser_out : register contents and status
interface univ_shift_reg_seq_if #(
    parameter int N  = 8,
    parameter int AW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    op;
    logic [AW-1:0] amount;
    logic [N-1:0]  load_data;
    logic          serial_l;
    logic          serial_r;
    logic [N-1:0]  Q;
    logic          busy;
    logic          done;
    logic          ser_out;

    modport master (
        output cmd_valid, op, amount, load_data, serial_l, serial_r,
        input  cmd_ready, Q, busy, done, ser_out
    );

    modport slave (
        input  cmd_valid, op, amount, load_data, serial_l, serial_r,
        output cmd_ready, Q, busy, done, ser_out
    );
endinterface

// File: rtl/univ_shift_reg_seq.sv
// Universal shift/rotate register. One command per handshake: NOP, LOAD,
// CLEAR execute in a single edge; SHL/SHR/SAR/ROL/ROR by k > 0 positions
// run one position per clock in the SHIFT state (busy high), and done pulses
// for one cycle in the first cycle Q shows the final result.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears Q/status and aborts a shift
//   bus   : command/status interface (slave modport)
module univ_shift_reg_seq #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    univ_shift_reg_seq_if.slave   bus
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_SAR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_q, w_q_nxt;
    logic [2:0]    r_op, w_op_nxt;
    logic [AW-1:0] r_cnt, w_cnt_nxt;
    logic          r_done, w_done_nxt;
    logic          r_ser, w_ser_nxt;
    logic          w_accept;
    logic          w_is_shift;

    // One step of the latched operation; serial fill bits are the live inputs.
    function automatic logic [N-1:0] f_step(input logic [2:0] op,
                                            input logic [N-1:0] q,
                                            input logic sl,
                                            input logic sr);
        case (op)
            OP_SHL:  f_step = {q[N-2:0], sl};
            OP_SHR:  f_step = {sr, q[N-1:1]};
            OP_SAR:  f_step = {q[N-1], q[N-1:1]};
            OP_ROL:  f_step = {q[N-2:0], q[N-1]};
            OP_ROR:  f_step = {q[0], q[N-1:1]};
            default: f_step = q;
        endcase
    endfunction

    // Bit leaving the register on one step: MSB for left moves, LSB otherwise.
    function automatic logic f_out(input logic [2:0] op, input logic [N-1:0] q);
        if (op == OP_SHL || op == OP_ROL)
            f_out = q[N-1];
        else
            f_out = q[0];
    endfunction

    assign w_accept   = bus.cmd_valid && (r_state == IDLE);
    assign w_is_shift = (bus.op >= OP_SHL) && (bus.op <= OP_ROR);

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_ser_nxt   = r_ser;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (bus.amount != '0)) begin
                        // Q stays put on the accept edge; stepping starts next edge.
                        w_op_nxt    = bus.op;
                        w_cnt_nxt   = bus.amount;
                        w_state_nxt = SHIFT;
                    end else begin
                        // Zero-amount shifts fall through here and behave as NOP.
                        w_done_nxt = 1'b1;
                        if (bus.op == OP_LOAD)
                            w_q_nxt = bus.load_data;
                        else if (bus.op == OP_CLEAR)
                            w_q_nxt = '0;
                    end
                end
            end
            SHIFT: begin
                w_q_nxt   = f_step(r_op, r_q, bus.serial_l, bus.serial_r);
                w_ser_nxt = f_out(r_op, r_q);
                w_cnt_nxt = r_cnt - AW'(1);
                if (r_cnt == AW'(1)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_op    <= OP_NOP;
            r_cnt   <= '0;
            r_ser   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ser   <= w_ser_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.busy      = (r_state == SHIFT);
    assign bus.cmd_ready = (r_state != SHIFT);
    assign bus.Q         = r_q;
    assign bus.done      = r_done;
    assign bus.ser_out   = r_ser;

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Bench for univ_shift_reg_seq: an 8-bit instance checked every cycle against a
// closed-form model (result of n steps computed directly from the start value),
// directed scenarios with literal results, randomized commands, and a 16-bit
// instance for the long-rotate case.
module tb_univ_shift_reg_seq;

    localparam int N  = 8;
    localparam int AW = 4;

    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] LOAD  = 3'b001;
    localparam logic [2:0] SHL   = 3'b010;
    localparam logic [2:0] SHR   = 3'b011;
    localparam logic [2:0] SAR   = 3'b100;
    localparam logic [2:0] ROL   = 3'b101;
    localparam logic [2:0] ROR   = 3'b110;
    localparam logic [2:0] CLEAR = 3'b111;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    univ_shift_reg_seq_if #(.N(N), .AW(AW)) bus ();
    univ_shift_reg_seq_if #(.N(16), .AW(5)) bus16 ();

    univ_shift_reg_seq #(.N(N), .AW(AW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    univ_shift_reg_seq #(.N(16), .AW(5)) dut16 (
        .clock(clock),
        .reset(reset),
        .bus  (bus16)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: m_q is the committed value (start value while a shift runs).
    logic [N-1:0] m_q;
    logic         m_ser;
    logic         m_busy;
    logic         m_done;
    logic [2:0]   m_op;
    int           m_k;
    int           m_j;
    logic         m_fill;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Value after n steps of op from q, fill bit held constant.
    function automatic logic [N-1:0] m_shift(input logic [N-1:0] q, input logic [2:0] op,
                                             input int n, input logic fill);
        logic [N-1:0]        ones;
        logic signed [N-1:0] s;
        int                  r;
        ones = '1;
        r    = n % N;
        s    = q;
        case (op)
            SHL: m_shift = (n >= N) ? {N{fill}} : ((q << n) | (fill ? ~(ones << n) : '0));
            SHR: m_shift = (n >= N) ? {N{fill}} : ((q >> n) | (fill ? ~(ones >> n) : '0));
            SAR: begin
                s = s >>> ((n >= N) ? N - 1 : n);
                m_shift = s;
            end
            ROL: m_shift = (q << r) | (q >> (N - r));
            ROR: m_shift = (q >> r) | (q << (N - r));
            default: m_shift = q;
        endcase
    endfunction

    // Bit shifted out on step j (j >= 1) starting from q.
    function automatic logic m_out(input logic [N-1:0] q, input logic [2:0] op,
                                   input int j, input logic fill);
        case (op)
            SHL: m_out = (j <= N) ? q[N - j] : fill;
            SHR: m_out = (j <= N) ? q[j - 1] : fill;
            SAR: m_out = q[(j <= N) ? j - 1 : N - 1];
            ROL: m_out = q[(N - (j % N)) % N];
            ROR: m_out = q[(j - 1) % N];
            default: m_out = 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_q = '0; m_ser = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_op = NOP; m_k = 0; m_j = 0; m_fill = 1'b0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (m_busy) begin
            m_j++;
            if (m_j == m_k) begin
                m_ser  = m_out(m_q, m_op, m_k, m_fill);
                m_q    = m_shift(m_q, m_op, m_k, m_fill);
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (bus.cmd_valid) begin
            if (bus.op >= SHL && bus.op <= ROR && bus.amount != 0) begin
                m_busy = 1'b1;
                m_op   = bus.op;
                m_k    = int'(bus.amount);
                m_j    = 0;
                m_fill = (bus.op == SHL) ? bus.serial_l : bus.serial_r;
            end else begin
                m_done = 1'b1;
                if (bus.op == LOAD)  m_q = bus.load_data;
                if (bus.op == CLEAR) m_q = '0;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] eq;
        logic         es;
        eq = m_busy ? m_shift(m_q, m_op, m_j, m_fill) : m_q;
        es = (m_busy && m_j > 0) ? m_out(m_q, m_op, m_j, m_fill) : m_ser;
        chk("Q", bus.Q, eq);
        chk("ser_out", bus.ser_out, es);
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, m_done);
        chk("cmd_ready", bus.cmd_ready, !m_busy);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare();
    endtask

    // Returns the number of cycles advanced until done is seen (bounded).
    task automatic wait_done(input bit wide, input string nm, output int cyc);
        int i;
        for (i = 0; i < 64; i++) begin
            if (wide ? bus16.done : bus.done) break;
            cycle();
        end
        cyc = i;
        n_checks++;
        if (i == 64) begin
            n_err++;
            $display("FAIL %s_timeout: no done within 64 cycles, required a done pulse", nm);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] amt,
                         input logic [N-1:0] d, input logic sl, input logic sr,
                         input string nm, output int cyc);
        bus.op = op; bus.amount = amt; bus.load_data = d;
        bus.serial_l = sl; bus.serial_r = sr; bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_valid = 1'b0;
        wait_done(1'b0, nm, cyc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bcnt;
        logic sl, sr;
        bus.cmd_valid = 0; bus.op = NOP; bus.amount = '0; bus.load_data = '0;
        bus.serial_l = 0; bus.serial_r = 0;
        bus16.cmd_valid = 0; bus16.op = NOP; bus16.amount = '0; bus16.load_data = '0;
        bus16.serial_l = 0; bus16.serial_r = 0;
        model_reset();

        // Reset state
        repeat (2) cycle();
        chk("rst_Q", bus.Q, 8'h00);
        chk("rst_ready", bus.cmd_ready, 1'b1);
        reset = 1'b0;
        cycle();

        // Load and rotate
        issue(LOAD, 4'd0, 8'hA5, 0, 0, "load_a5", cyc);
        chk("load_a5_lat", cyc, 0);
        chk("load_a5_Q", bus.Q, 8'hA5);
        issue(ROL, 4'd3, 8'h00, 0, 0, "rol3", cyc);
        chk("rol3_lat", cyc, 3);
        chk("rol3_Q", bus.Q, 8'h2D);
        chk("rol3_ser", bus.ser_out, 1'b1);
        issue(ROR, 4'd8, 8'h00, 0, 0, "ror8", cyc);
        chk("ror8_lat", cyc, 8);
        chk("ror8_Q", bus.Q, 8'h2D);

        // Serial fill and shifts
        issue(LOAD, 4'd0, 8'h81, 0, 0, "load_81", cyc);
        issue(SHR, 4'd2, 8'h00, 0, 1, "shr2", cyc);
        chk("shr2_Q", bus.Q, 8'hE0);
        chk("shr2_ser", bus.ser_out, 1'b0);
        issue(LOAD, 4'd0, 8'h90, 0, 0, "load_90", cyc);
        issue(SAR, 4'd4, 8'h00, 0, 0, "sar4", cyc);
        chk("sar4_Q", bus.Q, 8'hF9);
        issue(SHL, 4'd9, 8'h00, 0, 0, "shl9", cyc);
        chk("shl9_Q", bus.Q, 8'h00);

        // Handshake: LOAD FF held valid during a 4-step SHL
        issue(LOAD, 4'd0, 8'h3C, 0, 0, "load_3c", cyc);
        bus.op = SHL; bus.amount = 4'd4; bus.serial_l = 1'b1; bus.cmd_valid = 1'b1;
        cycle();
        bus.op = LOAD; bus.load_data = 8'hFF;
        bcnt = 0;
        for (int i = 0; i < 32 && !bus.done; i++) begin
            if (bus.busy) bcnt++;
            cycle();
        end
        chk("hs_busy_cycles", bcnt, 4);
        chk("hs_Q_at_done", bus.Q, 8'hCF);
        chk("hs_ready_at_done", bus.cmd_ready, 1'b1);
        cycle();
        bus.cmd_valid = 1'b0;
        chk("hs_Q_loaded", bus.Q, 8'hFF);
        chk("hs_done_load", bus.done, 1'b1);
        cycle();
        chk("hs_done_once", bus.done, 1'b0);

        // Zero-amount shift, then CLEAR
        issue(SHL, 4'd0, 8'h00, 1, 1, "shl0", cyc);
        chk("shl0_lat", cyc, 0);
        chk("shl0_Q", bus.Q, 8'hFF);
        chk("shl0_busy", bus.busy, 1'b0);
        cycle();
        chk("shl0_done_drop", bus.done, 1'b0);
        issue(CLEAR, 4'd0, 8'h00, 0, 0, "clear", cyc);
        chk("clear_Q", bus.Q, 8'h00);

        // Reset mid-operation
        issue(LOAD, 4'd0, 8'hA5, 0, 0, "load_a5b", cyc);
        bus.op = ROL; bus.amount = 4'd5; bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_valid = 1'b0;
        cycle();
        cycle();
        chk("mid_Q_2steps", bus.Q, 8'h96);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("arst_Q", bus.Q, 8'h00);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        cycle();
        reset = 1'b0;
        chk("arst_ready", bus.cmd_ready, 1'b1);
        issue(LOAD, 4'd0, 8'h5A, 0, 0, "load_after_rst", cyc);
        chk("load_after_rst_Q", bus.Q, 8'h5A);

        // 16-bit instance: ROL 31 of 0001
        bus16.op = LOAD; bus16.load_data = 16'h0001; bus16.cmd_valid = 1'b1;
        cycle();
        bus16.cmd_valid = 1'b0;
        wait_done(1'b1, "w16_load", cyc);
        chk("w16_load_Q", bus16.Q, 16'h0001);
        bus16.op = ROL; bus16.amount = 5'd31; bus16.cmd_valid = 1'b1;
        cycle();
        bus16.cmd_valid = 1'b0;
        wait_done(1'b1, "w16_rol31", cyc);
        chk("w16_rol31_lat", cyc, 31);
        chk("w16_rol31_Q", bus16.Q, 16'h8000);

        // Randomized commands, serial bits held per command, junk while busy
        for (int c = 0; c < 400; c++) begin
            sl = 1'($urandom_range(0, 1));
            sr = 1'($urandom_range(0, 1));
            bus.op = 3'($urandom_range(0, 7));
            bus.amount = AW'($urandom_range(0, 15));
            bus.load_data = N'($urandom);
            bus.serial_l = sl; bus.serial_r = sr;
            bus.cmd_valid = 1'b1;
            cycle();
            for (int w = 0; m_busy; w++) begin
                if (w >= 20) begin
                    n_checks++; n_err++;
                    $display("FAIL rand_busy_bound: model busy beyond 20 cycles, required completion");
                    break;
                end
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.op = 3'($urandom_range(0, 7));
                bus.amount = AW'($urandom_range(0, 15));
                bus.load_data = N'($urandom);
                cycle();
            end
            repeat ($urandom_range(0, 2)) begin
                bus.cmd_valid = 1'b0;
                cycle();
            end
        end
        bus.cmd_valid = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
